// File: rtl/ssd_scan.sv
// Multiplexed seven-segment driver: double-buffered nibble display register,
// prescaled digit scan, hex/BCD decode, leading-zero blanking, registered pins.
module ssd_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  ssd_clk,
    input  logic                  ssd_rst,
    input  logic                  ssd_load,
    input  logic [4*DIGITS-1:0]   ssd_din,
    input  logic [DIGITS-1:0]     ssd_dp,
    input  logic                  ssd_sel,
    input  logic                  ssd_blank_lz,
    output logic [DIGITS-1:0]     ssd_an,
    output logic [6:0]            ssd_seg,
    output logic                  ssd_dpo,
    output logic                  ssd_frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_POL  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                pend_v_q, pend_v_d;
    logic                wrap_q, frame_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpo_q, dpo_d;
    logic                tc_s, bound_s, dig_blank_s;
    logic [DIGITS-1:0]   blank_s;
    logic [3:0]          nib_s;

    // Active-high segment pattern {g,f,e,d,c,b,a}; BCD mode turns A..F into a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] nib, input logic bcd);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return (bcd && (nib > 4'd9)) ? 7'h40 : s;
    endfunction

    // Scan timing and the pending/display double buffer
    always_comb begin
        tc_s      = (presc_q == PW'(REFRESH_DIV - 1));
        bound_s   = tc_s && (idx_q == IW'(DIGITS - 1));
        presc_d   = tc_s ? {PW{1'b0}} : presc_q + PW'(1);
        if (bound_s) begin
            idx_d = {IW{1'b0}};
        end else if (tc_s) begin
            idx_d = idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end
        disp_d    = disp_q;
        disp_dp_d = disp_dp_q;
        pend_d    = pend_q;
        pend_dp_d = pend_dp_q;
        pend_v_d  = pend_v_q;
        // A load landing on the boundary bypasses the pending stage entirely
        if (bound_s && ssd_load) begin
            disp_d    = ssd_din;
            disp_dp_d = ssd_dp;
            pend_v_d  = 1'b0;
        end else if (bound_s && pend_v_q) begin
            disp_d    = pend_q;
            disp_dp_d = pend_dp_q;
            pend_v_d  = 1'b0;
        end else if (ssd_load) begin
            pend_d    = ssd_din;
            pend_dp_d = ssd_dp;
            pend_v_d  = 1'b1;
        end else begin
            pend_v_d  = pend_v_q;
        end
    end

    // Leading-zero mask and next pin values for the digit currently indexed
    always_comb begin
        logic lead;
        lead    = 1'b1;
        blank_s = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead       = lead & (disp_q[4*i +: 4] == 4'h0) & ~disp_dp_q[i];
            blank_s[i] = lead & ssd_blank_lz;
        end
        blank_s[0]  = 1'b0;
        nib_s       = disp_q[4*idx_q +: 4];
        dig_blank_s = blank_s[idx_q];
        if (dig_blank_s) begin
            an_d  = AN_POL;
            seg_d = SEG_POL;
            dpo_d = ACTIVE_LOW;
        end else begin
            an_d  = (DIGITS'(1'b1) << idx_q) ^ AN_POL;
            seg_d = seg_decode(nib_s, ssd_sel) ^ SEG_POL;
            dpo_d = disp_dp_q[idx_q] ^ ACTIVE_LOW;
        end
    end

    // All state; frame is delayed twice so it lines up with digit 0 on the pins
    always_ff @(posedge ssd_clk or posedge ssd_rst) begin
        if (ssd_rst) begin
            presc_q   <= {PW{1'b0}};
            idx_q     <= {IW{1'b0}};
            disp_q    <= {(4*DIGITS){1'b0}};
            disp_dp_q <= {DIGITS{1'b0}};
            pend_q    <= {(4*DIGITS){1'b0}};
            pend_dp_q <= {DIGITS{1'b0}};
            pend_v_q  <= 1'b0;
            wrap_q    <= 1'b0;
            frame_q   <= 1'b0;
            an_q      <= AN_POL;
            seg_q     <= SEG_POL;
            dpo_q     <= ACTIVE_LOW;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            disp_dp_q <= disp_dp_d;
            pend_q    <= pend_d;
            pend_dp_q <= pend_dp_d;
            pend_v_q  <= pend_v_d;
            wrap_q    <= bound_s;
            frame_q   <= wrap_q;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dpo_q     <= dpo_d;
        end
    end

    assign ssd_an    = an_q;
    assign ssd_seg   = seg_q;
    assign ssd_dpo   = dpo_q;
    assign ssd_frame = frame_q;

endmodule

// File: doc/ssd_scan.md
Name: ssd_scan

Overview:
- Multiplexed seven-segment display driver: the consumer end of the 4-bit up/down counter outputs.
- Accepts a packed word of nibbles (one per digit) from one or more counters and latches it on a load strobe.
- Time-multiplexes the digits onto a shared segment bus with a prescaled scan.
- Sits between the counter blocks and the board display pins.

Parameters:
- DIGITS, 4, number of display digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit stays enabled (>=2).
- ACTIVE_LOW, 1, 1 = segment and anode outputs active-low; 0 = active-high.

Ports:
- ssd_clk  in  1  system clock, all state on rising edge.
- ssd_rst  in  1  asynchronous active-high reset.
- ssd_load  in  1  load strobe; samples ssd_din and ssd_dp.
- ssd_din  in  4*DIGITS  packed nibbles; [3:0] = digit 0 (rightmost).
- ssd_dp  in  DIGITS  decimal-point request per digit.
- ssd_sel  in  1  0 = hex decode; 1 = BCD decode (nibble >9 shows dash).
- ssd_blank_lz  in  1  1 = blank leading zero digits.
- ssd_an  out  DIGITS  one-hot digit enable.
- ssd_seg  out  7  segments {g,f,e,d,c,b,a}.
- ssd_dpo  out  1  decimal point of the enabled digit.
- ssd_frame  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

Behaviour:
- Clock and reset: one clock, ssd_clk. Reset ssd_rst is asynchronous and active-high.
- Reset state:
  - prescaler = 0, digit index = 0.
  - display register and pending register = 0; pending flag = 0.
  - ssd_an, ssd_seg, ssd_dpo all inactive (all 1 when ACTIVE_LOW=1); ssd_frame = 0.
- Reset mid-frame: takes effect immediately and discards pending data.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - Terminal count (TC) advances the digit index modulo DIGITS.
- Frame boundary:
  - Defined as TC with index = DIGITS-1.
  - ssd_frame asserts on the cycle after the boundary, aligned with the output change to digit 0.
- Load path, double buffered (no tearing mid-frame):
  - ssd_load writes ssd_din and ssd_dp into the pending register and sets the pending flag.
  - At a frame boundary with pending=1: display register <= pending register; pending flag cleared.
  - ssd_load coincident with the boundary: the new ssd_din/ssd_dp transfer directly to the display register and pending stays 0.
  - Repeated loads within a frame: last one wins.
- Decode (active-high form; inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - ssd_sel=1 and nibble A..F: dash = 40. ssd_sel is sampled live, not latched.
- Leading-zero blanking (ssd_blank_lz=1):
  - A digit is blanked if it and every more-significant digit are 0 and its dp bit is 0.
  - Digit 0 is never blanked.
  - Blanked digit: anode inactive, segments inactive, dp inactive.
- Outputs are registered:
  - ssd_an/ssd_seg/ssd_dpo reflect the digit index one cycle after it changes.
  - First valid digit-0 drive appears on the first clock after reset release.
  - Exactly one anode is active except for blanked slots; no two anodes are ever active together.

Test Plan (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1):
- Reset release, no load -> ssd_an cycles 1110,1101,1011,0111, each held 4 cycles. ssd_seg=40 (zero) on every digit. ssd_frame pulses once per 16 cycles.
- Load ssd_din=16'h1234 mid-frame (digit 1) -> digits keep showing 0 until the frame boundary. Next frame: digit0 seg=19 (4), digit1=30 (3), digit2=24 (2), digit3=79 (1).
- ssd_sel=1, display 16'h00AF -> digits 0 and 1 show dash (seg=3F). ssd_sel=0 -> seg=0E (F) and 08 (A).
- ssd_blank_lz=1, display 16'h0050 with ssd_dp=0000 -> digits 3 and 2 have anode inactive, digit1=12 (5), digit0=40. Then ssd_dp=0100 -> digit 2 shows 40 with ssd_dpo=0.
- ssd_load asserted exactly on the boundary cycle with 16'h9999 -> digit 0 of the next frame shows 10 (9). Pending flag is 0 after the transfer.
- Assert ssd_rst for one cycle mid-frame with pending data -> outputs immediately inactive. After release: index 0, display register 0, pending data discarded.
